// File: rtl/rv32i_types.sv
// Shared type definitions for the rv32i memory subsystem.
package rv32i_types;

    // Memory arbiter FSM: waiting for a request, or holding one open against memory.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: returns the first set request bit strictly after
// last_grant, wrapping around, so the most recently served port is searched last.
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] grant
);

    int                   cand_int;
    logic [IDX_WIDTH-1:0] cand_idx;

    // Walk the ports in rotated order and keep the first requester found.
    always_comb begin
        valid    = 1'b0;
        grant    = '0;
        cand_int = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand_int = (int'(last_grant) + k) % NUM_PORTS;
            cand_idx = cand_int[IDX_WIDTH-1:0];
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                grant = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin arbiter in front of a single hold-until-resp memory port.
// One transaction is open at a time; all mem_* outputs come straight from flops.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   req_byte_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [BE_WIDTH-1:0]             mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_resp,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    arb_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0] grant_q, grant_d;
    logic [IDX_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [BE_WIDTH-1:0]  be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_PORTS-1:0] req_any;
    logic                 pick_valid;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_write;
    logic [BE_WIDTH-1:0]  pick_be;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;
    logic                 resp_fire;

    assign req_any = req_read | req_write;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req        (req_any),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .grant      (pick_idx)
    );

    // Mux out the chosen port's request fields; a write strobe overrides a read.
    always_comb begin
        pick_write = 1'b0;
        pick_be    = '0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick_idx == IDX_WIDTH'(p)) begin
                pick_write = req_write[p];
                pick_be    = req_byte_enable[p*BE_WIDTH +: BE_WIDTH];
                pick_addr  = req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: grant and latch in IDLE, wait for mem_resp in BUSY.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d     = ARB_BUSY;
                    grant_d     = pick_idx;
                    mem_write_d = pick_write;
                    mem_read_d  = !pick_write;
                    be_d        = pick_write ? pick_be : '1;
                    addr_d      = pick_addr;
                    wdata_d     = pick_wdata;
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_q;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and latched transaction registers; reset gives port 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_WIDTH'(NUM_PORTS - 1);
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Completion is steered back in the same cycle; a stray mem_resp in IDLE is dropped.
    assign resp_fire = (state_q == ARB_BUSY) && mem_resp;
    assign req_resp  = resp_fire ? (NUM_PORTS'(1) << grant_q) : '0;
    assign req_rdata = resp_fire ? mem_rdata : '0;

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;

    // A master raising read and write together is a protocol error upstream.
    a_no_rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
        ((req_read & req_write) == '0));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a 2-port and a 3-port instance.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // 2-port instance signals
    logic [1:0]  rd2, wr2;
    logic [7:0]  be2;
    logic [63:0] addr2, wdata2;
    logic [1:0]  resp2;
    logic [31:0] rdata2;
    logic        mread2, mwrite2;
    logic [3:0]  mbe2;
    logic [31:0] maddr2, mwdata2;
    logic        mresp2;
    logic [31:0] mrdata2;

    // 3-port instance signals
    logic [2:0]  rd3, wr3;
    logic [11:0] be3;
    logic [95:0] addr3, wdata3;
    logic [2:0]  resp3;
    logic [31:0] rdata3;
    logic        mread3, mwrite3;
    logic [3:0]  mbe3;
    logic [31:0] maddr3, mwdata3;
    logic        mresp3;
    logic [31:0] mrdata3;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_read        (rd2),
        .req_write       (wr2),
        .req_byte_enable (be2),
        .req_address     (addr2),
        .req_wdata       (wdata2),
        .req_resp        (resp2),
        .req_rdata       (rdata2),
        .mem_read        (mread2),
        .mem_write       (mwrite2),
        .mem_byte_enable (mbe2),
        .mem_address     (maddr2),
        .mem_wdata       (mwdata2),
        .mem_resp        (mresp2),
        .mem_rdata       (mrdata2)
    );

    mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_read        (rd3),
        .req_write       (wr3),
        .req_byte_enable (be3),
        .req_address     (addr3),
        .req_wdata       (wdata3),
        .req_resp        (resp3),
        .req_rdata       (rdata3),
        .mem_read        (mread3),
        .mem_write       (mwrite3),
        .mem_byte_enable (mbe3),
        .mem_address     (maddr3),
        .mem_wdata       (mwdata3),
        .mem_resp        (mresp3),
        .mem_rdata       (mrdata3)
    );

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one port of the 2-port instance.
    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be);
        rd2[port]              = rd;
        wr2[port]              = wr;
        addr2[port*32 +: 32]   = addr;
        wdata2[port*32 +: 32]  = wdata;
        be2[port*4 +: 4]       = be;
    endtask

    // Act as memory: wait (bounded) for a strobe, hold lat cycles, then pulse mem_resp.
    task automatic serveMem(input int which, input int lat, input logic [31:0] data,
                            output logic [7:0] respSeen, output logic [31:0] addrSeen);
        logic strobe;
        strobe = (which == 2) ? (mread2 | mwrite2) : (mread3 | mwrite3);
        for (int w = 0; w < 20 && !strobe; w++) begin
            @(negedge clk);
            strobe = (which == 2) ? (mread2 | mwrite2) : (mread3 | mwrite3);
        end
        checkOutput("serve_strobe", {63'd0, strobe}, 64'd1);
        addrSeen = (which == 2) ? maddr2 : maddr3;
        for (int c = 1; c < lat; c++) @(negedge clk);
        if (which == 2) begin
            mresp2  = 1'b1;
            mrdata2 = data;
        end else begin
            mresp3  = 1'b1;
            mrdata3 = data;
        end
        #1;
        respSeen = (which == 2) ? {6'd0, resp2} : {5'd0, resp3};
        checkOutput("serve_rdata", (which == 2) ? {32'd0, rdata2} : {32'd0, rdata3}, {32'd0, data});
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        logic [7:0]  respSeen;
        logic [31:0] addrSeen;

        rd2 = '0; wr2 = '0; be2 = '0; addr2 = '0; wdata2 = '0; mresp2 = 1'b0; mrdata2 = '0;
        rd3 = '0; wr3 = '0; be3 = '0; addr3 = '0; wdata3 = '0; mresp3 = 1'b0; mrdata3 = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_mem_read",  {63'd0, mread2},  64'd0);
        checkOutput("rst_mem_write", {63'd0, mwrite2}, 64'd0);
        checkOutput("rst_mem_addr",  {32'd0, maddr2},  64'd0);
        checkOutput("rst_mem_be",    {60'd0, mbe2},    64'd0);
        checkOutput("rst_req_resp",  {62'd0, resp2},   64'd0);
        checkOutput("rst_req_rdata", {32'd0, rdata2},  64'd0);
        checkOutput("rst3_mem_read", {63'd0, mread3},  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single read on port 0");
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t1_read_c1",  {63'd0, mread2},  64'd1);
        checkOutput("t1_write_c1", {63'd0, mwrite2}, 64'd0);
        checkOutput("t1_addr",     {32'd0, maddr2},  64'h100);
        checkOutput("t1_be",       {60'd0, mbe2},    64'hF);
        checkOutput("t1_noresp",   {62'd0, resp2},   64'd0);
        @(negedge clk);
        checkOutput("t1_read_c2",  {63'd0, mread2},  64'd1);
        @(negedge clk);
        checkOutput("t1_read_c3",  {63'd0, mread2},  64'd1);
        mresp2 = 1'b0;
        @(negedge clk);
        mresp2 = 1'b1; mrdata2 = 32'hDEAD_BEEF;
        #1;
        checkOutput("t1_read_c4",  {63'd0, mread2},  64'd1);
        checkOutput("t1_resp",     {62'd0, resp2},   64'd1);
        checkOutput("t1_rdata",    {32'd0, rdata2},  64'hDEAD_BEEF);
        @(negedge clk);
        mresp2 = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        checkOutput("t1_read_done", {63'd0, mread2}, 64'd0);
        checkOutput("t1_resp_done", {62'd0, resp2},  64'd0);

        $display("[TB] mem_resp while idle");
        mresp2 = 1'b1; mrdata2 = 32'h0000_CAFE;
        #1;
        checkOutput("idle_resp",  {62'd0, resp2},  64'd0);
        checkOutput("idle_rdata", {32'd0, rdata2}, 64'd0);
        @(negedge clk);
        mresp2 = 1'b0;
        checkOutput("idle_no_grant", {63'd0, mread2}, 64'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] simultaneous requests after reset");
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t2_first_addr", {32'd0, maddr2}, 64'h200);
        mresp2 = 1'b1; mrdata2 = 32'h1111_1111;
        #1;
        checkOutput("t2_first_resp", {62'd0, resp2}, 64'd1);
        @(negedge clk);
        mresp2 = 1'b0;
        rd2[0] = 1'b0;
        checkOutput("t2_gap_read", {63'd0, mread2}, 64'd0);
        checkOutput("t2_gap_addr", {32'd0, maddr2}, 64'h200);
        @(negedge clk);
        checkOutput("t2_second_addr", {32'd0, maddr2}, 64'h300);
        checkOutput("t2_second_read", {63'd0, mread2}, 64'd1);
        mresp2 = 1'b1; mrdata2 = 32'h2222_2222;
        #1;
        checkOutput("t2_second_resp", {62'd0, resp2}, 64'd2);
        @(negedge clk);
        mresp2 = 1'b0;
        rd2[1] = 1'b0;

        $display("[TB] fairness with both ports held");
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        for (int t = 0; t < 4; t++) begin
            serveMem(2, 2, 32'hA000_0000 + 32'(t), respSeen, addrSeen);
            checkOutput("fair_resp", {56'd0, respSeen}, (t % 2 == 0) ? 64'd1 : 64'd2);
            checkOutput("fair_addr", {32'd0, addrSeen}, (t % 2 == 0) ? 64'h400 : 64'h500);
            @(negedge clk);
            mresp2 = 1'b0;
            if (t == 3) rd2 = '0;
        end
        @(negedge clk);

        $display("[TB] byte-enable write on port 1");
        applyStimulus(0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'b1100);
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        checkOutput("t4_write", {63'd0, mwrite2}, 64'd1);
        checkOutput("t4_read",  {63'd0, mread2},  64'd0);
        checkOutput("t4_be",    {60'd0, mbe2},    64'h3);
        checkOutput("t4_wdata", {32'd0, mwdata2}, 64'h1234_5678);
        checkOutput("t4_addr",  {32'd0, maddr2},  64'h40);
        serveMem(2, 1, 32'h0, respSeen, addrSeen);
        checkOutput("t4_resp", {56'd0, respSeen}, 64'd2);
        @(negedge clk);
        mresp2 = 1'b0;
        wr2 = '0;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b1100);
        @(negedge clk);
        checkOutput("t4_rd_be",    {60'd0, mbe2},    64'hF);
        checkOutput("t4_rd_write", {63'd0, mwrite2}, 64'd0);
        serveMem(2, 1, 32'h5555_5555, respSeen, addrSeen);
        checkOutput("t4_rd_resp", {56'd0, respSeen}, 64'd1);
        @(negedge clk);
        mresp2 = 1'b0;
        rd2 = '0;

        $display("[TB] reset mid-transaction");
        rd2[1] = 1'b1;
        addr2[63:32] = 32'h0000_0080;
        @(negedge clk);
        checkOutput("t5_busy_read", {63'd0, mread2}, 64'd1);
        checkOutput("t5_busy_addr", {32'd0, maddr2}, 64'h80);
        rst_n = 1'b0;
        mresp2 = 1'b1;
        rd2 = '0;
        #1;
        checkOutput("t5_rst_read",  {63'd0, mread2},  64'd0);
        checkOutput("t5_rst_write", {63'd0, mwrite2}, 64'd0);
        checkOutput("t5_rst_addr",  {32'd0, maddr2},  64'd0);
        checkOutput("t5_rst_be",    {60'd0, mbe2},    64'd0);
        checkOutput("t5_rst_wdata", {32'd0, mwdata2}, 64'd0);
        checkOutput("t5_rst_resp",  {62'd0, resp2},   64'd0);
        @(negedge clk);
        mresp2 = 1'b0;
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0088, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0090, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t5_after_addr", {32'd0, maddr2}, 64'h88);
        serveMem(2, 1, 32'h7777_7777, respSeen, addrSeen);
        checkOutput("t5_after_resp", {56'd0, respSeen}, 64'd1);
        @(negedge clk);
        mresp2 = 1'b0;
        rd2 = '0;

        $display("[TB] three-port rotation");
        rd3   = 3'b111;
        addr3 = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        for (int t = 0; t < 4; t++) begin
            serveMem(3, 2, 32'hB000_0000 + 32'(t), respSeen, addrSeen);
            checkOutput("rot_resp", {56'd0, respSeen}, 64'd1 << (t % 3));
            checkOutput("rot_addr", {32'd0, addrSeen}, 64'h1000 * 64'((t % 3) + 1));
            @(negedge clk);
            mresp3 = 1'b0;
            if (t == 3) rd3 = '0;
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
